// File: rtl/spin_state_interleaver_pkg.sv
// Shared types and defaults for the spin-state capture buffer.
// Defaults follow the galena macro readout: two snapshot sets of NUM_SPIN spins.
package spin_state_interleaver_pkg;

    localparam int DEF_NUM_SPIN    = 256;
    localparam int SPIN_ICON_DEPTH = 2;
    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_DEPTH       = SPIN_ICON_DEPTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Round-robin interleave: round r of channel c lands at r*num_ch + c.
    function automatic int entry_idx(input int rnd, input int ch, input int num_ch);
        return rnd * num_ch + ch;
    endfunction

endpackage

// File: rtl/spin_state_cmp.sv
// Readout checker: counts accepted entries whose state differs from the
// reference snapshot. Cleared by clr_i; holds its value otherwise.
module spin_state_cmp #(
    parameter int NUM_SPIN = 256,
    parameter int CW       = 2
)(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [NUM_SPIN-1:0] obs_i,
    input  logic [NUM_SPIN-1:0] ref_i,
    output logic [CW-1:0]       cnt_o
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (obs_i != ref_i)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/spin_state_interleaver.sv
// Captures NUM_CH snapshot streams into one interleaved memory, then streams it out.
// Optional readout compare against ref_state_i is enabled by SPIN_STATE_CMP_EN.
module spin_state_interleaver
    import spin_state_interleaver_pkg::*;
#(
    parameter  int NUM_SPIN = DEF_NUM_SPIN,
    parameter  int NUM_CH   = DEF_NUM_CH,
    parameter  int DEPTH    = DEF_DEPTH,
    localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int MCW      = $clog2(DEPTH + 1)
)(
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [NUM_CH-1:0]                in_valid_i,
    output logic [NUM_CH-1:0]                in_ready_o,
    input  logic [NUM_CH-1:0][NUM_SPIN-1:0]  in_state_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [NUM_SPIN-1:0]              out_state_o,
    output logic [IW-1:0]                    out_idx_o,
    output logic                             busy_o,
    output logic                             done_o
`ifdef SPIN_STATE_CMP_EN
    ,
    input  logic [NUM_SPIN-1:0]              ref_state_i,
    output logic [MCW-1:0]                   mismatch_cnt_o
`endif
);

    localparam int ROUNDS = DEPTH / NUM_CH;
    localparam int CW     = $clog2(ROUNDS + 1);

    state_e                   r_state;
    logic [NUM_CH-1:0][CW-1:0] r_wr_cnt;
    logic [IW-1:0]            r_rd_idx;
    logic                     r_done;
    logic [NUM_SPIN-1:0]      r_mem [DEPTH];

    logic [NUM_CH-1:0]        w_wr_fire;
    logic [NUM_CH-1:0]        w_ch_full_nxt;
    logic                     w_fill_last;
    logic                     w_rd_fire;
    logic                     w_drain_last;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign in_ready_o[c]    = (r_state == FILL) && (r_wr_cnt[c] < CW'(ROUNDS));
        assign w_ch_full_nxt[c] = (r_wr_cnt[c] + CW'(w_wr_fire[c])) == CW'(ROUNDS);
    end

    assign w_wr_fire    = in_valid_i & in_ready_o;
    // Looking at post-write counts lets DRAIN start the cycle after the last write.
    assign w_fill_last  = &w_ch_full_nxt;
    assign w_rd_fire    = out_valid_o && out_ready_i;
    assign w_drain_last = w_rd_fire && (r_rd_idx == IW'(DEPTH - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_wr_cnt <= '0;
            r_rd_idx <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_i) begin
                r_state  <= FILL;
                r_wr_cnt <= '0;
                r_rd_idx <= '0;
            end else begin
                case (r_state)
                    IDLE: ;
                    FILL: begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (w_wr_fire[c]) r_wr_cnt[c] <= r_wr_cnt[c] + CW'(1);
                        end
                        if (w_fill_last) r_state <= DRAIN;
                    end
                    DRAIN: begin
                        if (w_drain_last) begin
                            r_state  <= IDLE;
                            r_rd_idx <= '0;
                            r_done   <= 1'b1;
                        end else if (w_rd_fire) begin
                            r_rd_idx <= r_rd_idx + IW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Per-channel write addresses never collide, so all channels may write at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!start_i && w_wr_fire[c])
                    r_mem[IW'(entry_idx(int'(r_wr_cnt[c]), c, NUM_CH))] <= in_state_i[c];
            end
        end
    end

    assign out_valid_o = (r_state == DRAIN);
    assign out_state_o = out_valid_o ? r_mem[r_rd_idx] : '0;
    assign out_idx_o   = r_rd_idx;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;

`ifdef SPIN_STATE_CMP_EN
    spin_state_cmp #(
        .NUM_SPIN (NUM_SPIN),
        .CW       (MCW)
    ) u_cmp (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (start_i),
        .en_i     (w_rd_fire),
        .obs_i    (out_state_o),
        .ref_i    (ref_state_i),
        .cnt_o    (mismatch_cnt_o)
    );
`endif

endmodule

// File: tb/tb_spin_state_interleaver.sv
// Directed bench for spin_state_interleaver (NUM_CH=4, DEPTH=8) with a readout scoreboard.
// Compare-counter checks are active when SPIN_STATE_CMP_EN is defined.
module tb_spin_state_interleaver;

    localparam int NS = 16;
    localparam int NC = 4;
    localparam int DP = 8;
    localparam int RN = DP / NC;
    localparam int IW = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   start_i = 1'b0;
    logic [NC-1:0]          in_valid_i = '0;
    logic [NC-1:0]          in_ready_o;
    logic [NC-1:0][NS-1:0]  in_state_i = '0;
    logic                   out_valid_o;
    logic                   out_ready_i = 1'b0;
    logic [NS-1:0]          out_state_o;
    logic [IW-1:0]          out_idx_o;
    logic                   busy_o;
    logic                   done_o;

    logic [NS-1:0]          data [DP];

`ifdef SPIN_STATE_CMP_EN
    logic [NS-1:0]          ref_state_i;
    logic [3:0]             mismatch_cnt_o;
    logic [DP-1:0]          bad_mask = '0;
    assign ref_state_i = data[out_idx_o] ^ (bad_mask[out_idx_o] ? NS'(1) : NS'(0));
`endif

    spin_state_interleaver #(
        .NUM_SPIN (NS),
        .NUM_CH   (NC),
        .DEPTH    (DP)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_state_i     (in_state_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_state_o    (out_state_o),
        .out_idx_o      (out_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
`ifdef SPIN_STATE_CMP_EN
        ,
        .ref_state_i    (ref_state_i),
        .mismatch_cnt_o (mismatch_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            idx;
        logic [NS-1:0] st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Drives one fill; channel dly_ch is held off for dly cycles. Entry r*NC+c gets ch c round r.
    task automatic fill(input int dly_ch, input int dly);
        int            cnt [NC];
        int            cyc;
        logic [NC-1:0] fire;
        bit            all_done;
        cyc = 0;
        for (int c = 0; c < NC; c++) cnt[c] = 0;
        for (int e = 0; e < DP; e++) begin
            data[e] = NS'($urandom);
            sb.push_back('{idx: e, st: data[e]});
        end
        forever begin
            for (int c = 0; c < NC; c++) chk($sformatf("in_ready_ch%0d", c), 64'(in_ready_o[c]), 64'(cnt[c] < RN));
            chk("fill_out_valid", 64'(out_valid_o), 64'd0);
            chk("fill_done", 64'(done_o), 64'd0);
            for (int c = 0; c < NC; c++) begin
                in_valid_i[c] = (cnt[c] < RN) && !(c == dly_ch && cyc < dly);
                in_state_i[c] = (cnt[c] < RN) ? data[cnt[c] * NC + c] : '0;
            end
            fire = in_valid_i & in_ready_o;
            @(posedge clk_i);
            for (int c = 0; c < NC; c++) if (fire[c]) cnt[c]++;
            @(negedge clk_i);
            cyc++;
            all_done = 1'b1;
            for (int c = 0; c < NC; c++) if (cnt[c] != RN) all_done = 1'b0;
            if (all_done) break;
            if (cyc > 50) begin
                chk("fill_timeout", 64'd1, 64'd0);
                break;
            end
        end
        in_valid_i = '0;
        chk("drain_latency", 64'(out_valid_o), 64'd1);
        chk("drain_in_ready", 64'(in_ready_o), 64'd0);
    endtask

    // Drains with out_ready_i following pat (bit k%4). abort_at>=0 pulses start_i with the handshake at that idx.
    task automatic drain(input logic [3:0] pat, input int abort_at);
        int            k;
        bit            stalled;
        bit            last;
        logic [NS-1:0] pst;
        logic [IW-1:0] pidx;
        exp_t          e;
        k = 0;
        stalled = 1'b0;
        pst = '0;
        pidx = '0;
        forever begin
            chk("drain_out_valid", 64'(out_valid_o), 64'd1);
            if (stalled) begin
                chk("stall_state", 64'(out_state_o), 64'(pst));
                chk("stall_idx", 64'(out_idx_o), 64'(pidx));
            end
            if (abort_at >= 0 && int'(out_idx_o) == abort_at) begin
                start_i = 1'b1;
                out_ready_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
                out_ready_i = 1'b0;
                chk("abort_busy", 64'(busy_o), 64'd1);
                chk("abort_out_valid", 64'(out_valid_o), 64'd0);
                chk("abort_idx", 64'(out_idx_o), 64'd0);
                chk("abort_in_ready", 64'(in_ready_o), 64'hF);
                chk("abort_done", 64'(done_o), 64'd0);
                sb.delete();
                return;
            end
            out_ready_i = pat[k % 4];
            last = 1'b0;
            if (out_ready_i) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 64'd1, 64'd0);
                    out_ready_i = 1'b0;
                    return;
                end
                e = sb.pop_front();
                chk("out_state", 64'(out_state_o), 64'(e.st));
                chk("out_idx", 64'(out_idx_o), 64'(e.idx));
                last = (sb.size() == 0);
            end
            stalled = !out_ready_i;
            pst = out_state_o;
            pidx = out_idx_o;
            @(negedge clk_i);
            k++;
            if (last) begin
                out_ready_i = 1'b0;
                chk("done_pulse", 64'(done_o), 64'd1);
                chk("end_out_valid", 64'(out_valid_o), 64'd0);
                chk("end_busy", 64'(busy_o), 64'd0);
                @(negedge clk_i);
                chk("done_once", 64'(done_o), 64'd0);
                return;
            end
            if (k > 100) begin
                chk("drain_timeout", 64'd1, 64'd0);
                out_ready_i = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        chk("rst_out_idx", 64'(out_idx_o), 64'd0);
        chk("rst_out_state", 64'(out_state_o), 64'd0);
`ifdef SPIN_STATE_CMP_EN
        chk("rst_mismatch", 64'(mismatch_cnt_o), 64'd0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;

        // full-rate run
        pulse_start();
        fill(-1, 0);
        drain(4'b1111, -1);

        // ch2 late, readout backpressure 1,0,0,1
        pulse_start();
        fill(2, 5);
        drain(4'b1001, -1);

        // abort at idx 2 together with a handshake, then a clean run
        pulse_start();
        fill(-1, 0);
        drain(4'b1111, 2);
        fill(-1, 0);
        drain(4'b1111, -1);

        // async reset mid-fill after one write
        pulse_start();
        in_valid_i[0] = 1'b1;
        in_state_i[0] = 16'hBEEF;
        @(posedge clk_i);
        #2;
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_in_ready", 64'(in_ready_o), 64'd0);
        chk("arst_out_valid", 64'(out_valid_o), 64'd0);
        chk("arst_out_idx", 64'(out_idx_o), 64'd0);
        chk("arst_out_state", 64'(out_state_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        in_valid_i = '0;
        in_state_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle", 64'(busy_o), 64'd0);
        pulse_start();
        fill(-1, 0);
        drain(4'b1111, -1);

`ifdef SPIN_STATE_CMP_EN
        pulse_start();
        fill(-1, 0);
        bad_mask = 8'b0000_1010;
        drain(4'b1111, -1);
        chk("mismatch_at_done", 64'(mismatch_cnt_o), 64'd2);
        bad_mask = '0;
        pulse_start();
        chk("mismatch_cleared", 64'(mismatch_cnt_o), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spin_state_interleaver.md
# spin_state_interleaver

Synthesizable capture buffer for spin-state snapshots leaving the galena analog macro. It accepts NUM_CH independent per-channel snapshot streams and stores them round-robin interleaved into one DEPTH-entry memory: entry r*NUM_CH+c holds channel c's r-th snapshot. It then streams the entries out in index order. It sits between the macro's readout channels and the digital result path or scoreboard, and generalises the fixed two-set shuffle of the behaviour model to any channel count and depth.

## Interface
- NUM_SPIN, 256, bits per spin snapshot
- NUM_CH, 2, number of input channels; must be ≥1
- DEPTH, 2, total entries; must be a multiple of NUM_CH; ROUNDS = DEPTH/NUM_CH
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse; clears counters and begins capture
- in_valid_i  in  NUM_CH  per-channel snapshot valid
- in_ready_o  out  NUM_CH  per-channel ready
- in_state_i  in  NUM_CH×NUM_SPIN  per-channel snapshot, packed [NUM_CH-1:0][NUM_SPIN-1:0]
- out_valid_o  out  1  readout entry valid
- out_ready_i  in  1  readout consumer ready
- out_state_o  out  NUM_SPIN  entry at out_idx_o
- out_idx_o  out  $clog2(DEPTH) (min 1)  current readout index
- busy_o  out  1  high in FILL or DRAIN
- done_o  out  1  one-cycle pulse after the last entry is consumed

## Operation
- FSM states: IDLE, FILL, DRAIN.
- IDLE: all readies low, out_valid_o low. start_i moves the FSM to FILL.
- FILL: each channel c has a counter wr_cnt[c] in 0..ROUNDS.
  - in_ready_o[c] = (state==FILL) && (wr_cnt[c] < ROUNDS).
  - When in_valid_i[c] && in_ready_o[c], the block writes in_state_i[c] to mem[wr_cnt[c]*NUM_CH + c] and increments wr_cnt[c].
  - Channels are independent. Any subset may write in the same cycle because their addresses are always distinct. One channel may finish early while others continue.
  - When every wr_cnt equals ROUNDS, the next state is DRAIN.
- DRAIN: out_valid_o=1, out_state_o=mem[rd_idx], out_idx_o=rd_idx.
  - On out_valid_o && out_ready_i, rd_idx increments.
  - On acceptance at rd_idx=DEPTH-1, the next state is IDLE and done_o pulses in that next cycle.
- start_i in FILL or DRAIN aborts and restarts. The next state is FILL, all wr_cnt and rd_idx are cleared, and no done_o is generated. start_i beats a simultaneous final handshake.
- Memory contents persist across start_i. Stale entries are overwritten by the new fill before they can be read.
- Reset values: state IDLE; all counters 0; mem all-zero; in_ready_o=0, out_valid_o=0, out_state_o=0, out_idx_o=0, busy_o=0, done_o=0.
- Reset asserted mid-FILL or mid-DRAIN returns the block to IDLE immediately. In-flight data is discarded.

## Timing
- in_ready_o and out_valid_o are decoded from registered state only. They never depend combinationally on in_valid_i or out_ready_i.
- In DRAIN, out_state_o is a combinational read of mem at the registered rd_idx.
- Latency from the last input handshake to out_valid_o=1 is 1 cycle.
- Maximum throughput: NUM_CH writes per cycle in FILL and 1 read per cycle in DRAIN.
- For a full-rate run, the minimum cycles from start_i to done_o are 1 + ROUNDS + 1 + DEPTH.

## Configuration
- Macro SPIN_STATE_CMP_EN.
- Defined:
  - Adds port ref_state_i (in, NUM_SPIN), the expected snapshot for the current out_idx_o.
  - Adds port mismatch_cnt_o (out, $clog2(DEPTH+1)).
  - mismatch_cnt_o increments on each DRAIN handshake where out_state_o != ref_state_i.
  - The count is cleared by start_i or reset and held after done_o.
- Undefined: both ports are absent and there is no compare logic.

## Structure
- In the galena package:
  - FSM enum typedef (IDLE/FILL/DRAIN).
  - Default NUM_CH/DEPTH constants, tied to SPIN_ICON_DEPTH and NUM_SPIN.
  - A function mapping (round, channel) to an entry index.
- One sub-module: spin_state_cmp, the equality compare plus saturating-free counter. It is instantiated only under SPIN_STATE_CMP_EN.

## Test plan
- NUM_CH=2, DEPTH=4, all valids held high:
  - ch0 sends A0,A1 and ch1 sends B0,B1.
  - Readout order must be A0,B0,A1,B1 with idx 0..3.
  - done_o pulses once.
- NUM_CH=4, DEPTH=8, ch2 delayed 5 cycles:
  - ch0, ch1 and ch3 must deassert ready after 2 writes each.
  - DRAIN must start exactly 1 cycle after ch2's second write.
- Readout backpressure: out_ready_i toggles 1,0,0,1.
  - out_state_o and out_idx_o must hold stable while stalled.
  - No entry may be skipped or repeated.
- start_i pulsed at idx=2 of DRAIN, simultaneous with a handshake:
  - The FSM must re-enter FILL and rd_idx must return to 0.
  - done_o must stay low.
- rst_ni asserted mid-FILL after 1 write:
  - All outputs must go to reset values asynchronously.
  - The next start_i runs a clean fill.
- With SPIN_STATE_CMP_EN, DEPTH=4 and ref_state_i correct except at idx 1 and 3:
  - mismatch_cnt_o must equal 2 at done_o.
  - It must read 0 after the next start_i.
